// File: rtl/pkt_dmux_pkg.sv
// Shared definitions for the egress packet demultiplexer: framing tags,
// controller states and the port-mask helper.
package pkt_dmux_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned TAG_W     = 2;

  localparam logic [TAG_W-1:0] TAG_HEAD = 2'b01;
  localparam logic [TAG_W-1:0] TAG_BODY = 2'b11;
  localparam logic [TAG_W-1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    XFER    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  // Isolate the lowest set bit of a port bitmap (zero stays zero).
  function automatic logic [MAX_PORTS-1:0] lowest_onehot(input logic [MAX_PORTS-1:0] mask);
    return mask & (~mask + MAX_PORTS'(1));
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: q presents the head entry while not empty,
// rd pops it. Writes while full and reads while empty are ignored.
// Synchronous active-low reset clears the occupancy.
module sync_fifo_sa #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         d,
  input  logic                     rd,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign q     = mem[rd_ptr];
  assign usedw = count;

  // Storage array; no reset needed, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= d;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_dmux_n.sv
// Egress demultiplexer: buffers packets, strips the two metadata words and
// forwards the body to the port(s) selected by the metadata bitmap.
// Optional build macro PKT_DMUX_MULTICAST_EN honours multi-bit bitmaps;
// without it the lowest set bit selects a single port.
module pkt_dmux_n
  import pkt_dmux_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 5,
  parameter int unsigned DATA_W       = 134,
  parameter int unsigned PORT_LSB     = 64,
  parameter int unsigned DEFAULT_PORT = 0,
  parameter int unsigned FIFO_AW      = 8,
  parameter int unsigned AFULL_LEVEL  = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_egress_pkt_wr,
  input  logic [DATA_W-1:0]    in_egress_pkt,
  input  logic                 in_egress_pkt_valid_wr,
  input  logic                 in_egress_pkt_valid,
  output logic                 out_egress_pkt_almostfull,
  output logic [DATA_W-1:0]    out_pkt,
  output logic [NUM_PORTS-1:0] out_pkt_wr,
  output logic [NUM_PORTS-1:0] out_pkt_valid_wr,
  output logic                 out_pkt_valid,
  input  logic [NUM_PORTS-1:0] in_port_almostfull,
  output logic                 dmux_receive_pkt_add,
  output logic                 dmux_discard_error_pkt_add,
  output logic                 dmux_discard_runt_pkt_add,
  output logic [NUM_PORTS-1:0] dmux_send_pkt_add
);

  localparam int unsigned DATA_DEPTH = 1 << FIFO_AW;
  localparam int unsigned VLD_DEPTH  = 64;
  localparam int unsigned VLD_UW     = $clog2(VLD_DEPTH) + 1;
  localparam logic [NUM_PORTS-1:0] DEFAULT_MASK = NUM_PORTS'(1) << DEFAULT_PORT;

  // Buffer status
  logic [DATA_W-1:0]    data_q;
  logic                 data_empty;
  logic [FIFO_AW:0]     data_usedw;
  logic                 data_rd;
  logic                 vld_q;
  logic                 vld_empty;
  logic [VLD_UW-1:0]    unused_vld_usedw;
  logic                 vld_rd;
  logic [TAG_W-1:0]     data_tag;

  // Controller state and next values
  state_e               state, state_nxt;
  logic [NUM_PORTS-1:0] bitmap, bitmap_nxt;
  logic                 first, first_nxt;
  logic [NUM_PORTS-1:0] dest_mask_c;

  logic [DATA_W-1:0]    out_pkt_nxt;
  logic [NUM_PORTS-1:0] out_pkt_wr_nxt;
  logic [NUM_PORTS-1:0] out_pkt_valid_wr_nxt;
  logic                 out_pkt_valid_nxt;
  logic                 receive_nxt;
  logic                 discard_error_nxt;
  logic                 discard_runt_nxt;
  logic [NUM_PORTS-1:0] send_nxt;

  sync_fifo_sa #(
    .WIDTH (DATA_W),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_egress_pkt_wr),
    .d     (in_egress_pkt),
    .rd    (data_rd),
    .q     (data_q),
    .empty (data_empty),
    .usedw (data_usedw)
  );

  sync_fifo_sa #(
    .WIDTH (1),
    .DEPTH (VLD_DEPTH)
  ) u_valid_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_egress_pkt_valid_wr),
    .d     (in_egress_pkt_valid),
    .rd    (vld_rd),
    .q     (vld_q),
    .empty (vld_empty),
    .usedw (unused_vld_usedw)
  );

  assign data_tag = data_q[DATA_W-1 -: TAG_W];
  assign out_egress_pkt_almostfull = (data_usedw >= (FIFO_AW+1)'(AFULL_LEVEL));

  // Destination mask from the latched bitmap; empty bitmap falls back to DEFAULT_PORT.
`ifdef PKT_DMUX_MULTICAST_EN
  assign dest_mask_c = (bitmap == '0) ? DEFAULT_MASK : bitmap;
`else
  assign dest_mask_c = (bitmap == '0) ? DEFAULT_MASK
                                      : NUM_PORTS'(lowest_onehot(MAX_PORTS'(bitmap)));
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                      <= IDLE;
      bitmap                     <= '0;
      first                      <= 1'b0;
      out_pkt                    <= '0;
      out_pkt_wr                 <= '0;
      out_pkt_valid_wr           <= '0;
      out_pkt_valid              <= 1'b0;
      dmux_receive_pkt_add       <= 1'b0;
      dmux_discard_error_pkt_add <= 1'b0;
      dmux_discard_runt_pkt_add  <= 1'b0;
      dmux_send_pkt_add          <= '0;
    end else begin
      state                      <= state_nxt;
      bitmap                     <= bitmap_nxt;
      first                      <= first_nxt;
      out_pkt                    <= out_pkt_nxt;
      out_pkt_wr                 <= out_pkt_wr_nxt;
      out_pkt_valid_wr           <= out_pkt_valid_wr_nxt;
      out_pkt_valid              <= out_pkt_valid_nxt;
      dmux_receive_pkt_add       <= receive_nxt;
      dmux_discard_error_pkt_add <= discard_error_nxt;
      dmux_discard_runt_pkt_add  <= discard_runt_nxt;
      dmux_send_pkt_add          <= send_nxt;
    end
  end

  // Next-state, FIFO pops and next output values.
  always_comb begin
    state_nxt            = state;
    bitmap_nxt           = bitmap;
    first_nxt            = first;
    data_rd              = 1'b0;
    vld_rd               = 1'b0;
    out_pkt_nxt          = out_pkt;
    out_pkt_wr_nxt       = '0;
    out_pkt_valid_wr_nxt = '0;
    out_pkt_valid_nxt    = 1'b0;
    receive_nxt          = 1'b0;
    discard_error_nxt    = 1'b0;
    discard_runt_nxt     = 1'b0;
    send_nxt             = '0;

    case (state)
      IDLE: begin
        if (!vld_empty && !data_empty) begin
          vld_rd  = 1'b1;
          data_rd = 1'b1;
          if (!vld_q) begin
            // A single-word error packet is already fully consumed here.
            if (data_tag == TAG_TAIL) begin
              discard_error_nxt = 1'b1;
            end else begin
              state_nxt = DISCARD;
            end
          end else if (data_tag == TAG_TAIL) begin
            discard_runt_nxt = 1'b1;
          end else begin
            bitmap_nxt = data_q[PORT_LSB +: NUM_PORTS];
            state_nxt  = SELECT;
          end
        end
      end

      SELECT: begin
        if (((in_port_almostfull & dest_mask_c) == '0) && !data_empty) begin
          data_rd = 1'b1;
          if (data_tag == TAG_TAIL) begin
            discard_runt_nxt = 1'b1;
            state_nxt        = IDLE;
          end else begin
            receive_nxt = 1'b1;
            first_nxt   = 1'b1;
            state_nxt   = XFER;
          end
        end
      end

      XFER: begin
        if (!data_empty) begin
          data_rd        = 1'b1;
          out_pkt_nxt    = data_q;
          out_pkt_wr_nxt = dest_mask_c;
          first_nxt      = 1'b0;
          if (first) begin
            out_pkt_nxt[DATA_W-1 -: TAG_W] = TAG_HEAD;
          end
          if (data_tag == TAG_TAIL) begin
            out_pkt_valid_wr_nxt = dest_mask_c;
            out_pkt_valid_nxt    = 1'b1;
            send_nxt             = dest_mask_c;
            state_nxt            = IDLE;
          end
        end
      end

      DISCARD: begin
        if (!data_empty) begin
          data_rd = 1'b1;
          if (data_tag == TAG_TAIL) begin
            discard_error_nxt = 1'b1;
            state_nxt         = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pkt_dmux_n.sv
// Self-checking bench for pkt_dmux_n: a scoreboard queue of expected output
// words plus per-scenario pulse and timing checks.
module tb_pkt_dmux_n;

  localparam int NP = 5;
  localparam int DW = 134;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_egress_pkt_wr;
  logic [DW-1:0]  in_egress_pkt;
  logic           in_egress_pkt_valid_wr;
  logic           in_egress_pkt_valid;
  logic           out_egress_pkt_almostfull;
  logic [DW-1:0]  out_pkt;
  logic [NP-1:0]  out_pkt_wr;
  logic [NP-1:0]  out_pkt_valid_wr;
  logic           out_pkt_valid;
  logic [NP-1:0]  in_port_almostfull;
  logic           dmux_receive_pkt_add;
  logic           dmux_discard_error_pkt_add;
  logic           dmux_discard_runt_pkt_add;
  logic [NP-1:0]  dmux_send_pkt_add;

  pkt_dmux_n #(
    .NUM_PORTS    (NP),
    .DATA_W       (DW),
    .PORT_LSB     (64),
    .DEFAULT_PORT (3),
    .FIFO_AW      (8),
    .AFULL_LEVEL  (128)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .in_egress_pkt_wr           (in_egress_pkt_wr),
    .in_egress_pkt              (in_egress_pkt),
    .in_egress_pkt_valid_wr     (in_egress_pkt_valid_wr),
    .in_egress_pkt_valid        (in_egress_pkt_valid),
    .out_egress_pkt_almostfull  (out_egress_pkt_almostfull),
    .out_pkt                    (out_pkt),
    .out_pkt_wr                 (out_pkt_wr),
    .out_pkt_valid_wr           (out_pkt_valid_wr),
    .out_pkt_valid              (out_pkt_valid),
    .in_port_almostfull         (in_port_almostfull),
    .dmux_receive_pkt_add       (dmux_receive_pkt_add),
    .dmux_discard_error_pkt_add (dmux_discard_error_pkt_add),
    .dmux_discard_runt_pkt_add  (dmux_discard_runt_pkt_add),
    .dmux_send_pkt_add          (dmux_send_pkt_add)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] mask;
    logic [DW-1:0] data;
    bit            first;
    bit            last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   tail_cyc    = 0;
  int   last_gap    = -1;
  int   recv_cnt    = 0;
  int   err_cnt     = 0;
  int   runt_cnt    = 0;
  int   wr_cnt   [NP];
  int   send_cnt [NP];

  function automatic logic [DW-1:0] rand_word(input logic [1:0] tag);
    logic [159:0] r;
    logic [DW-1:0] w;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w = DW'(r);
    w[DW-1 -: 2] = tag;
    return w;
  endfunction

  // Reference port selection: zero -> port 3, else lowest bit (or all bits with multicast).
  function automatic logic [NP-1:0] exp_dest(input logic [NP-1:0] bm);
    if (bm == '0) return 5'b01000;
`ifdef PKT_DMUX_MULTICAST_EN
    return bm;
`else
    for (int i = 0; i < NP; i++) begin
      if (bm[i]) return NP'(1) << i;
    end
    return '0;
`endif
  endfunction

  function automatic int total_wr();
    int s = 0;
    for (int i = 0; i < NP; i++) s += wr_cnt[i];
    return s;
  endfunction

  task automatic write_word(input logic [DW-1:0] w);
    in_egress_pkt_wr = 1'b1;
    in_egress_pkt    = w;
    @(posedge clk); #1;
    in_egress_pkt_wr = 1'b0;
  endtask

  task automatic write_valid(input logic v);
    in_egress_pkt_valid_wr = 1'b1;
    in_egress_pkt_valid    = v;
    @(posedge clk); #1;
    in_egress_pkt_valid_wr = 1'b0;
  endtask

  // Two metadata words + nbody body words; expectations pushed for good packets.
  task automatic write_pkt(input logic [NP-1:0] bm, input int nbody, input bit good);
    logic [DW-1:0] w;
    logic [NP-1:0] m;
    exp_t e;
    m = exp_dest(bm);
    w = rand_word(2'b01);
    w[64 +: NP] = bm;
    write_word(w);
    write_word(rand_word(2'b11));
    for (int i = 0; i < nbody; i++) begin
      w = rand_word((i == nbody - 1) ? 2'b10 : 2'b11);
      if (good) begin
        e.mask  = m;
        e.data  = w;
        e.first = (i == 0);
        e.last  = (i == nbody - 1);
        if (i == 0) e.data[DW-1 -: 2] = 2'b01;
        exp_q.push_back(e);
      end
      write_word(w);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words never appeared (required 0)", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (dmux_receive_pkt_add === 1'b1) recv_cnt++;
      if (dmux_discard_error_pkt_add === 1'b1) err_cnt++;
      if (dmux_discard_runt_pkt_add === 1'b1) runt_cnt++;
      for (int i = 0; i < NP; i++) begin
        if (dmux_send_pkt_add[i] === 1'b1) send_cnt[i]++;
        if (out_pkt_wr[i] === 1'b1) wr_cnt[i]++;
      end
      if (out_pkt_wr !== '0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_word: unexpected write mask=%b data=%h (required no write)", out_pkt_wr, out_pkt);
        end else begin
          e = exp_q.pop_front();
          if (out_pkt_wr !== e.mask || out_pkt !== e.data ||
              out_pkt_valid_wr !== (e.last ? e.mask : 5'b0) ||
              dmux_send_pkt_add !== (e.last ? e.mask : 5'b0) ||
              out_pkt_valid !== e.last) begin
            miscompares++;
            $display("FAIL out_word: got wr=%b vwr=%b v=%b send=%b data=%h, required wr=%b last=%0d data=%h",
                     out_pkt_wr, out_pkt_valid_wr, out_pkt_valid, dmux_send_pkt_add, out_pkt,
                     e.mask, e.last, e.data);
          end
          if (e.first) last_gap = cyc - tail_cyc;
          if (e.last) tail_cyc = cyc;
        end
      end else if (out_pkt_valid_wr !== '0 || dmux_send_pkt_add !== '0) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_eop: vwr=%b send=%b without write (required 0)", out_pkt_valid_wr, dmux_send_pkt_add);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (out_pkt_wr !== '0 || out_pkt_valid_wr !== '0 || out_pkt_valid !== 1'b0 ||
        out_pkt !== '0 || dmux_receive_pkt_add !== 1'b0 || dmux_discard_error_pkt_add !== 1'b0 ||
        dmux_discard_runt_pkt_add !== 1'b0 || dmux_send_pkt_add !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs wr=%b vwr=%b v=%b pkt=%h recv=%b err=%b runt=%b send=%b (required all 0)",
               name, out_pkt_wr, out_pkt_valid_wr, out_pkt_valid, out_pkt, dmux_receive_pkt_add,
               dmux_discard_error_pkt_add, dmux_discard_runt_pkt_add, dmux_send_pkt_add);
    end
    vectors++;
    if (out_egress_pkt_almostfull !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_afull: got %b required 0", name, out_egress_pkt_almostfull);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    int r0 = recv_cnt, s2 = send_cnt[2], w2 = wr_cnt[2];
    write_pkt(5'b00100, 4, 1);
    write_valid(1'b1);
    drain(15);
    vectors++;
    if (wr_cnt[2] - w2 != 4 || send_cnt[2] - s2 != 1 || recv_cnt - r0 != 1) begin
      miscompares++;
      $display("FAIL good_counts: writes=%0d send=%0d recv=%0d required 4/1/1", wr_cnt[2] - w2, send_cnt[2] - s2, recv_cnt - r0);
    end
  endtask

  task automatic test_error();
    int e0 = err_cnt, t0 = total_wr(), s0 = send_cnt[0];
    write_pkt(5'b00100, 4, 0);
    write_valid(1'b0);
    drain(15);
    vectors++;
    if (err_cnt - e0 != 1 || total_wr() != t0) begin
      miscompares++;
      $display("FAIL error_drop: err=%0d writes=%0d required 1/0", err_cnt - e0, total_wr() - t0);
    end
    write_pkt(5'b00001, 5, 1);
    write_valid(1'b1);
    drain(15);
    vectors++;
    if (send_cnt[0] - s0 != 1) begin
      miscompares++;
      $display("FAIL error_next_pkt: send[0]=%0d required 1", send_cnt[0] - s0);
    end
  endtask

  task automatic test_runt();
    int u0 = runt_cnt, r0 = recv_cnt, t0 = total_wr();
    logic [DW-1:0] w;
    w = rand_word(2'b01);
    w[64 +: NP] = 5'b00100;
    write_word(w);
    write_word(rand_word(2'b10));
    write_valid(1'b1);
    write_word(rand_word(2'b10));
    write_valid(1'b1);
    drain(12);
    vectors++;
    if (runt_cnt - u0 != 2 || recv_cnt != r0 || total_wr() != t0) begin
      miscompares++;
      $display("FAIL runt: runt=%0d recv=%0d writes=%0d required 2/0/0", runt_cnt - u0, recv_cnt - r0, total_wr() - t0);
    end
  endtask

  task automatic test_backpressure();
    int w1, n;
    in_port_almostfull = 5'b00010;
    write_pkt(5'b00010, 4, 1);
    write_valid(1'b1);
    w1 = wr_cnt[1];
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (wr_cnt[1] != w1) begin
      miscompares++;
      $display("FAIL bp_hold: %0d writes while almostfull (required 0)", wr_cnt[1] - w1);
    end
    in_port_almostfull = '0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (out_pkt_wr[1] === 1'b1) break;
      n++;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL bp_release_latency: got %0d cycles required 2", n);
    end
    drain(10);
  endtask

  task automatic test_default_port();
    int s3 = send_cnt[3];
    write_pkt(5'b00000, 4, 1);
    write_valid(1'b1);
    drain(15);
    vectors++;
    if (send_cnt[3] - s3 != 1) begin
      miscompares++;
      $display("FAIL default_port: send[3]=%0d required 1", send_cnt[3] - s3);
    end
  endtask

  task automatic test_multi_bit();
    int s1 = send_cnt[1], s2 = send_cnt[2], req2;
`ifdef PKT_DMUX_MULTICAST_EN
    req2 = 1;
`else
    req2 = 0;
`endif
    write_pkt(5'b00110, 5, 1);
    write_valid(1'b1);
    drain(15);
    vectors++;
    if (send_cnt[1] - s1 != 1 || send_cnt[2] - s2 != req2) begin
      miscompares++;
      $display("FAIL multi_bit: send[1]=%0d send[2]=%0d required 1/%0d", send_cnt[1] - s1, send_cnt[2] - s2, req2);
    end
  endtask

  task automatic test_back_to_back();
    write_pkt(5'b00001, 4, 1);
    write_pkt(5'b10000, 3, 1);
    write_valid(1'b1);
    write_valid(1'b1);
    last_gap = -1;
    drain(25);
    vectors++;
    if (last_gap != 3) begin
      miscompares++;
      $display("FAIL b2b_gap: tail-to-head got %0d cycles required 3", last_gap);
    end
  endtask

  task automatic test_almostfull();
    int e0 = err_cnt;
    write_word(rand_word(2'b01));
    for (int i = 1; i < 127; i++) write_word(rand_word(2'b11));
    vectors++;
    if (out_egress_pkt_almostfull !== 1'b0) begin
      miscompares++;
      $display("FAIL afull_127: got %b required 0", out_egress_pkt_almostfull);
    end
    write_word(rand_word(2'b11));
    vectors++;
    if (out_egress_pkt_almostfull !== 1'b1) begin
      miscompares++;
      $display("FAIL afull_128: got %b required 1", out_egress_pkt_almostfull);
    end
    write_word(rand_word(2'b11));
    write_word(rand_word(2'b10));
    write_valid(1'b0);
    drain(140);
    vectors++;
    if (out_egress_pkt_almostfull !== 1'b0 || err_cnt - e0 != 1) begin
      miscompares++;
      $display("FAIL afull_drain: afull=%b err=%0d required 0/1", out_egress_pkt_almostfull, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int w4 = wr_cnt[4], s4 = send_cnt[4], r0, t0, n;
    write_pkt(5'b10000, 12, 1);
    write_valid(1'b1);
    n = 0;
    while (n < 40 && wr_cnt[4] == w4) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (wr_cnt[4] == w4) begin
      miscompares++;
      $display("FAIL reset_mid_start: no write seen within 40 cycles (required one)");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_idle_outputs("reset_mid");
    exp_q.delete();
    r0 = recv_cnt;
    t0 = total_wr();
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (send_cnt[4] != s4 || total_wr() != t0 || recv_cnt != r0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: send=%0d writes=%0d recv=%0d after reset (required 0/0/0)",
               send_cnt[4] - s4, total_wr() - t0, recv_cnt - r0);
    end
    write_pkt(5'b01000, 4, 1);
    write_valid(1'b1);
    drain(15);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      wr_cnt[i]   = 0;
      send_cnt[i] = 0;
    end
    reset                  = 1'b0;
    in_egress_pkt_wr       = 1'b0;
    in_egress_pkt          = '0;
    in_egress_pkt_valid_wr = 1'b0;
    in_egress_pkt_valid    = 1'b0;
    in_port_almostfull     = '0;
    test_reset();
    fork
      monitor();
    join_none
    test_good();
    test_error();
    test_runt();
    test_backpressure();
    test_default_port();
    test_multi_bit();
    test_back_to_back();
    test_almostfull();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
